// File: rtl/mux_n_reg_if.sv
// Operand-select bus for mux_n_reg: packed data inputs, select and pipeline
// controls going in, the registered operand and error status coming out.
interface mux_n_reg_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    stall;
    logic                    flush;
    logic                    clr_err;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    sel_err;
    logic [7:0]              err_count;

    modport master (
        output in_data, sel, in_valid, stall, flush, clr_err,
        input  out_data, out_valid, sel_err, err_count
    );

    modport slave (
        input  in_data, sel, in_valid, stall, flush, clr_err,
        output out_data, out_valid, sel_err, err_count
    );
endinterface

// File: rtl/mux_n_reg.sv
// N-to-1 operand selector with a registered output stage for forwarding paths.
// Flush beats stall beats a normal update. Out-of-range selects on accepted
// cycles produce a valid zero operand and are recorded in a sticky flag and a
// saturating 8-bit counter.
module mux_n_reg #(
    parameter int WIDTH        = 32,
    parameter int NUM_IN       = 3,
    parameter bit HOLD_ON_IDLE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_n_reg_if.slave   bus
);
    localparam int SEL_W = $clog2(NUM_IN);
    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_IN);

    logic [WIDTH-1:0] mux_d;
    logic             sel_oob;
    logic             accepted;
    logic             new_err;

    logic [WIDTH-1:0] out_data_d,  out_data_q;
    logic             out_valid_d, out_valid_q;
    logic             sel_err_d,   sel_err_q;
    logic [7:0]       err_count_d, err_count_q;

    // Select the addressed input; an index past the last input yields zero
    always_comb begin
        mux_d   = '0;
        sel_oob = ({1'b0, bus.sel} >= NUM_IN_W);
        for (int k = 0; k < NUM_IN; k++) begin
            if (!sel_oob && (bus.sel == k[SEL_W-1:0])) begin
                mux_d = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next state of the output stage: flush, then stall, then load or idle
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (bus.flush) begin
            out_data_d  = '0;
            out_valid_d = 1'b0;
        end else if (bus.stall) begin
            out_data_d  = out_data_q;
            out_valid_d = out_valid_q;
        end else if (bus.in_valid) begin
            out_data_d  = mux_d;
            out_valid_d = 1'b1;
        end else begin
            out_valid_d = 1'b0;
            out_data_d  = HOLD_ON_IDLE ? out_data_q : '0;
        end
    end

    // Error bookkeeping; a clear still records an error from the same cycle
    always_comb begin
        accepted    = bus.in_valid && !bus.stall && !bus.flush;
        new_err     = accepted && sel_oob;
        sel_err_d   = sel_err_q;
        err_count_d = err_count_q;
        if (bus.clr_err) begin
            sel_err_d   = new_err;
            err_count_d = new_err ? 8'd1 : 8'd0;
        end else if (new_err) begin
            sel_err_d = 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // State registers, cleared immediately when reset is asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sel_err   = sel_err_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_mux_n_reg.sv
// Scoreboard bench for mux_n_reg: one instance holding on idle and one
// clearing on idle, both fed the same stimulus.
module tb_mux_n_reg;
    logic clk;
    logic rst_n;

    mux_n_reg_if #(.WIDTH(32), .NUM_IN(3)) bus ();
    mux_n_reg_if #(.WIDTH(32), .NUM_IN(3)) bus_h0 ();

    mux_n_reg #(.WIDTH(32), .NUM_IN(3), .HOLD_ON_IDLE(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mux_n_reg #(.WIDTH(32), .NUM_IN(3), .HOLD_ON_IDLE(1'b0)) dut_h0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_h0)
    );

    assign bus_h0.in_data  = bus.in_data;
    assign bus_h0.sel      = bus.sel;
    assign bus_h0.in_valid = bus.in_valid;
    assign bus_h0.stall    = bus.stall;
    assign bus_h0.flush    = bus.flush;
    assign bus_h0.clr_err  = bus.clr_err;

    typedef struct {
        logic [31:0] data;
        logic [31:0] data0;
        logic        valid;
        logic        err;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        expQ[$];
    int          assertCount = 0;
    int          failCount   = 0;

    logic [31:0] din [3];
    logic [31:0] mData;
    logic [31:0] mData0;
    logic        mValid;
    logic        mErr;
    logic [7:0]  mCnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic setInputs(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        din[0] = a;
        din[1] = b;
        din[2] = c;
        bus.in_data = {c, b, a};
    endtask

    task automatic resetModel();
        mData  = '0;
        mData0 = '0;
        mValid = 1'b0;
        mErr   = 1'b0;
        mCnt   = 8'd0;
    endtask

    task automatic checkAll(input string tag, input exp_t e);
        checkOutput({tag, ".data"},  bus.out_data,               e.data);
        checkOutput({tag, ".data0"}, bus_h0.out_data,            e.data0);
        checkOutput({tag, ".valid"}, {31'd0, bus.out_valid},     {31'd0, e.valid});
        checkOutput({tag, ".valid0"},{31'd0, bus_h0.out_valid},  {31'd0, e.valid});
        checkOutput({tag, ".err"},   {31'd0, bus.sel_err},       {31'd0, e.err});
        checkOutput({tag, ".cnt"},   {24'd0, bus.err_count},     {24'd0, e.cnt});
        checkOutput({tag, ".cnt0"},  {24'd0, bus_h0.err_count},  {24'd0, e.cnt});
    endtask

    // Drive one cycle, predict the registered result, then compare after the edge
    task automatic applyStimulus(input string tag, input int s, input bit v,
                                 input bit st, input bit fl, input bit clr);
        logic [31:0] muxv;
        bit          acc;
        bit          ne;
        exp_t        e;
        @(negedge clk);
        bus.sel      = s[1:0];
        bus.in_valid = v;
        bus.stall    = st;
        bus.flush    = fl;
        bus.clr_err  = clr;
        muxv = (s < 3) ? din[s] : 32'd0;
        if (fl) begin
            mData = '0; mData0 = '0; mValid = 1'b0;
        end else if (!st) begin
            if (v) begin
                mData = muxv; mData0 = muxv; mValid = 1'b1;
            end else begin
                mData0 = '0; mValid = 1'b0;
            end
        end
        acc = v && !st && !fl;
        ne  = acc && (s >= 3);
        if (clr) begin
            mErr = ne;
            mCnt = ne ? 8'd1 : 8'd0;
        end else if (ne) begin
            mErr = 1'b1;
            if (mCnt != 8'd255) mCnt = mCnt + 8'd1;
        end
        e.data = mData; e.data0 = mData0; e.valid = mValid; e.err = mErr; e.cnt = mCnt;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checkOutput({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            checkAll(tag, expQ.pop_front());
        end
    endtask

    initial begin
        exp_t z;
        z.data = '0; z.data0 = '0; z.valid = 1'b0; z.err = 1'b0; z.cnt = 8'd0;
        rst_n = 1'b0;
        setInputs(32'h11111111, 32'h22222222, 32'h33333333);
        bus.sel = '0; bus.in_valid = 1'b0; bus.stall = 1'b0;
        bus.flush = 1'b0; bus.clr_err = 1'b0;
        resetModel();
        #12;
        checkAll("reset", z);
        @(negedge clk);
        rst_n = 1'b1;

        // Normal select of each input
        applyStimulus("sel0", 0, 1, 0, 0, 0);
        applyStimulus("sel1", 1, 1, 0, 0, 0);
        applyStimulus("sel2", 2, 1, 0, 0, 0);

        // Asynchronous reset in the middle of a cycle
        setInputs(32'hDEADBEEF, 32'h22222222, 32'h33333333);
        applyStimulus("loadDead", 0, 1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("asyncRst", z);
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        setInputs(32'h11111111, 32'h22222222, 32'h33333333);

        // Stall holds through changing selects; flush wins over stall
        applyStimulus("load22", 1, 1, 0, 0, 0);
        applyStimulus("stall0", 0, 1, 1, 0, 0);
        applyStimulus("stall2", 2, 1, 1, 0, 0);
        applyStimulus("stall3", 3, 1, 1, 0, 0);
        applyStimulus("stallFlush", 2, 1, 1, 1, 0);

        // Out-of-range select and the cycles that must not count it
        applyStimulus("oob", 3, 1, 0, 0, 0);
        applyStimulus("oobStall", 3, 1, 1, 0, 0);
        applyStimulus("oobFlush", 3, 1, 0, 1, 0);
        applyStimulus("oobIdle", 3, 0, 0, 0, 0);

        // Counter saturation after 260 accepted errors in total
        for (int i = 0; i < 259; i++) begin
            applyStimulus("oobSat", 3, 1, 0, 0, 0);
        end
        checkOutput("satCount", {24'd0, bus.err_count}, 32'd255);

        // Clearing with and without a simultaneous error
        applyStimulus("clrOob", 3, 1, 0, 0, 1);
        applyStimulus("clrOk", 0, 1, 0, 0, 1);

        // Idle handling after a load
        applyStimulus("load33", 2, 1, 0, 0, 0);
        applyStimulus("idle", 1, 0, 0, 0, 0);
        applyStimulus("idle2", 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
